// File: rtl/wifi_mac_hdr_parser_pkg.sv
// Shared 802.11 MAC header types and constants for the RX header parser.
package wifi_mac_hdr_parser_pkg;

    // Bit layout matches {fc_byte1, fc_byte0} so the raw field can be cast directly.
    typedef struct packed {
        logic       order;
        logic       prot;
        logic       more_data;
        logic       pwr_mgt;
        logic       retry;
        logic       more_frag;
        logic       from_ds;
        logic       to_ds;
        logic [3:0] subtype;
        logic [1:0] ftype;
        logic [1:0] version;
    } fc_t;

    localparam logic [1:0] TypeMgmt = 2'b00;
    localparam logic [1:0] TypeCtrl = 2'b01;
    localparam logic [1:0] TypeData = 2'b10;
    localparam logic [1:0] TypeRsvd = 2'b11;

    localparam logic [3:0] SubtypeCts = 4'b1100;
    localparam logic [3:0] SubtypeAck = 4'b1101;

    localparam logic [5:0] HdrLenCtrlShort = 6'd10;
    localparam logic [5:0] HdrLenCtrlLong  = 6'd16;
    localparam logic [5:0] HdrLenBase      = 6'd24;
    localparam logic [5:0] HdrLenA4        = 6'd30;
    localparam logic [5:0] HdrLenQos       = 6'd26;
    localparam logic [5:0] HdrLenA4Qos     = 6'd32;

endpackage

// File: rtl/wifi_mac_hdr_parser_fc_decode.sv
// Combinational frame-control decode: header length, address count and reject flags.
module wifi_mac_hdr_parser_fc_decode
    import wifi_mac_hdr_parser_pkg::*;
#(
    parameter bit QOS_EN   = 1'b1,
    parameter bit ADDR4_EN = 1'b1
) (
    input  logic [7:0] b0_i,
    input  logic [7:0] b1_i,
    output fc_t        fc_o,
    output logic [5:0] hdr_len_o,
    output logic [2:0] naddr_o,
    output logic       b0_err_o,
    output logic       err_o
);

    logic a4;
    logic qos;

    always_comb begin
        fc_o      = fc_t'({b1_i, b0_i});
        hdr_len_o = HdrLenBase;
        naddr_o   = 3'd3;
        a4        = fc_o.to_ds && fc_o.from_ds;
        qos       = QOS_EN && fc_o.subtype[3];
        b0_err_o  = (fc_o.version != 2'd0) || (fc_o.ftype == TypeRsvd);

        case (fc_o.ftype)
            TypeCtrl: begin
                if (fc_o.subtype[3] && (fc_o.subtype != SubtypeCts) &&
                    (fc_o.subtype != SubtypeAck)) begin
                    hdr_len_o = HdrLenCtrlLong;
                    naddr_o   = 3'd2;
                end else begin
                    hdr_len_o = HdrLenCtrlShort;
                    naddr_o   = 3'd1;
                end
            end
            TypeData: begin
                if (a4) begin
                    naddr_o   = 3'd4;
                    hdr_len_o = qos ? HdrLenA4Qos : HdrLenA4;
                end else begin
                    hdr_len_o = qos ? HdrLenQos : HdrLenBase;
                end
            end
            default: ;
        endcase

        err_o = b0_err_o || ((fc_o.ftype == TypeData) && a4 && !ADDR4_EN);
    end

endmodule

// File: rtl/wifi_mac_hdr_parser.sv
// 802.11 MPDU header parser: extracts header fields, forwards payload, drops bad frames.
module wifi_mac_hdr_parser
    import wifi_mac_hdr_parser_pkg::*;
#(
    parameter bit          QOS_EN   = 1'b1,
    parameter bit          ADDR4_EN = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic             hdr_valid_o,
    output fc_t              hdr_fc_o,
    output logic [15:0]      hdr_dur_o,
    output logic [47:0]      hdr_addr1_o,
    output logic [47:0]      hdr_addr2_o,
    output logic [47:0]      hdr_addr3_o,
    output logic [47:0]      hdr_addr4_o,
    output logic [2:0]       hdr_naddr_o,
    output logic [15:0]      hdr_seq_o,
    output logic [15:0]      hdr_qos_o,
    output logic             hdr_err_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StHdr     = 2'd1;
    localparam logic [1:0] StPayload = 2'd2;
    localparam logic [1:0] StDrop    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  idx_q, idx_d, len_q, len_d;
    logic [7:0]  b0_q, b0_d;
    fc_t         fc_q, fc_d;
    logic [2:0]  naddr_q, naddr_d;
    logic [15:0] sh_dur_q, sh_dur_d, sh_seq_q, sh_seq_d, sh_qos_q, sh_qos_d;
    logic [47:0] sh_a1_q, sh_a1_d, sh_a2_q, sh_a2_d, sh_a3_q, sh_a3_d, sh_a4_q, sh_a4_d;
    logic        hdr_valid_q, hdr_valid_d, hdr_err_q, hdr_err_d;
    fc_t         hdr_fc_q;
    logic [15:0] hdr_dur_q, hdr_seq_q, hdr_qos_q;
    logic [47:0] hdr_a1_q, hdr_a2_q, hdr_a3_q, hdr_a4_q;
    logic [2:0]  hdr_naddr_q;
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;
    logic        xfer;

    fc_t        dec_fc;
    logic [5:0] dec_len;
    logic [2:0] dec_naddr;
    logic       dec_b0_err, dec_err;

    // In IDLE the incoming byte is FC byte0, so decode it directly for early rejection.
    wifi_mac_hdr_parser_fc_decode #(
        .QOS_EN  (QOS_EN),
        .ADDR4_EN(ADDR4_EN)
    ) u_fc_decode (
        .b0_i     ((state_q == StIdle) ? s_data_i : b0_q),
        .b1_i     (s_data_i),
        .fc_o     (dec_fc),
        .hdr_len_o(dec_len),
        .naddr_o  (dec_naddr),
        .b0_err_o (dec_b0_err),
        .err_o    (dec_err)
    );

    always_comb begin
        s_ready_o   = (state_q == StPayload) ? m_ready_i : 1'b1;
        m_valid_o   = (state_q == StPayload) && s_valid_i;
        m_last_o    = (state_q == StPayload) && s_last_i;
        m_data_o    = (state_q == StPayload) ? s_data_i : 8'h00;
        xfer        = s_valid_i && s_ready_o;

        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        b0_d        = b0_q;
        fc_d        = fc_q;
        naddr_d     = naddr_q;
        sh_dur_d    = sh_dur_q;
        sh_seq_d    = sh_seq_q;
        sh_qos_d    = sh_qos_q;
        sh_a1_d     = sh_a1_q;
        sh_a2_d     = sh_a2_q;
        sh_a3_d     = sh_a3_q;
        sh_a4_d     = sh_a4_q;
        hdr_valid_d = 1'b0;
        hdr_err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (xfer) begin
                    b0_d     = s_data_i;
                    idx_d    = 6'd1;
                    sh_dur_d = '0;
                    sh_seq_d = '0;
                    sh_qos_d = '0;
                    sh_a1_d  = '0;
                    sh_a2_d  = '0;
                    sh_a3_d  = '0;
                    sh_a4_d  = '0;
                    if (dec_b0_err || s_last_i) begin
                        hdr_err_d = 1'b1;
                        state_d   = s_last_i ? StIdle : StDrop;
                    end else begin
                        state_d = StHdr;
                    end
                end
            end
            StHdr: begin
                if (xfer) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd1) begin
                        fc_d    = dec_fc;
                        len_d   = dec_len;
                        naddr_d = dec_naddr;
                        if (dec_err || s_last_i) begin
                            hdr_err_d = 1'b1;
                            state_d   = s_last_i ? StIdle : StDrop;
                        end
                    end else begin
                        // Little-endian fields: shift each byte in from the top.
                        if (idx_q < 6'd4) begin
                            sh_dur_d = {s_data_i, sh_dur_q[15:8]};
                        end else if (idx_q < 6'd10) begin
                            sh_a1_d = {s_data_i, sh_a1_q[47:8]};
                        end else if (idx_q < 6'd16) begin
                            sh_a2_d = {s_data_i, sh_a2_q[47:8]};
                        end else if (idx_q < 6'd22) begin
                            sh_a3_d = {s_data_i, sh_a3_q[47:8]};
                        end else if (idx_q < 6'd24) begin
                            sh_seq_d = {s_data_i, sh_seq_q[15:8]};
                        end else if ((naddr_q == 3'd4) && (idx_q < 6'd30)) begin
                            sh_a4_d = {s_data_i, sh_a4_q[47:8]};
                        end else begin
                            sh_qos_d = {s_data_i, sh_qos_q[15:8]};
                        end

                        if (idx_q == len_q - 6'd1) begin
                            hdr_valid_d = 1'b1;
                            state_d     = s_last_i ? StIdle : StPayload;
                        end else if (s_last_i) begin
                            hdr_err_d = 1'b1;
                            state_d   = StIdle;
                        end
                    end
                end
            end
            StPayload, StDrop: begin
                if (xfer && s_last_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            len_q       <= '0;
            b0_q        <= '0;
            fc_q        <= '0;
            naddr_q     <= '0;
            sh_dur_q    <= '0;
            sh_seq_q    <= '0;
            sh_qos_q    <= '0;
            sh_a1_q     <= '0;
            sh_a2_q     <= '0;
            sh_a3_q     <= '0;
            sh_a4_q     <= '0;
            hdr_valid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            hdr_fc_q    <= '0;
            hdr_dur_q   <= '0;
            hdr_seq_q   <= '0;
            hdr_qos_q   <= '0;
            hdr_a1_q    <= '0;
            hdr_a2_q    <= '0;
            hdr_a3_q    <= '0;
            hdr_a4_q    <= '0;
            hdr_naddr_q <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            b0_q        <= b0_d;
            fc_q        <= fc_d;
            naddr_q     <= naddr_d;
            sh_dur_q    <= sh_dur_d;
            sh_seq_q    <= sh_seq_d;
            sh_qos_q    <= sh_qos_d;
            sh_a1_q     <= sh_a1_d;
            sh_a2_q     <= sh_a2_d;
            sh_a3_q     <= sh_a3_d;
            sh_a4_q     <= sh_a4_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_err_q   <= hdr_err_d;
            if (hdr_valid_d) begin
                hdr_fc_q    <= fc_q;
                hdr_dur_q   <= sh_dur_d;
                hdr_seq_q   <= sh_seq_d;
                hdr_qos_q   <= sh_qos_d;
                hdr_a1_q    <= sh_a1_d;
                hdr_a2_q    <= sh_a2_d;
                hdr_a3_q    <= sh_a3_d;
                hdr_a4_q    <= sh_a4_d;
                hdr_naddr_q <= naddr_q;
            end
            if (hdr_valid_d && (frame_cnt_q != '1)) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            if (hdr_err_d && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hdr_valid_o = hdr_valid_q;
    assign hdr_err_o   = hdr_err_q;
    assign hdr_fc_o    = hdr_fc_q;
    assign hdr_dur_o   = hdr_dur_q;
    assign hdr_addr1_o = hdr_a1_q;
    assign hdr_addr2_o = hdr_a2_q;
    assign hdr_addr3_o = hdr_a3_q;
    assign hdr_addr4_o = hdr_a4_q;
    assign hdr_naddr_o = hdr_naddr_q;
    assign hdr_seq_o   = hdr_seq_q;
    assign hdr_qos_o   = hdr_qos_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_wifi_mac_hdr_parser.sv
// Self-checking bench for wifi_mac_hdr_parser with a payload scoreboard.
module tb_wifi_mac_hdr_parser;
    import wifi_mac_hdr_parser_pkg::*;

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b1;
    logic        hdr_valid, hdr_err;
    fc_t         hdr_fc;
    logic [15:0] hdr_dur, hdr_seq, hdr_qos;
    logic [47:0] hdr_addr1, hdr_addr2, hdr_addr3, hdr_addr4;
    logic [2:0]  hdr_naddr;
    logic [15:0] frame_cnt, err_cnt;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          hv_pulses = 0;
    int          err_pulses = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  obs_q[$];
    int unsigned hv_cyc_q[$];
    bit          bp_en = 1'b0;

    wifi_mac_hdr_parser #(
        .QOS_EN  (1'b1),
        .ADDR4_EN(1'b1),
        .CNT_W   (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_last_i   (s_last),
        .s_ready_o  (s_ready),
        .m_data_o   (m_data),
        .m_valid_o  (m_valid),
        .m_last_o   (m_last),
        .m_ready_i  (m_ready),
        .hdr_valid_o(hdr_valid),
        .hdr_fc_o   (hdr_fc),
        .hdr_dur_o  (hdr_dur),
        .hdr_addr1_o(hdr_addr1),
        .hdr_addr2_o(hdr_addr2),
        .hdr_addr3_o(hdr_addr3),
        .hdr_addr4_o(hdr_addr4),
        .hdr_naddr_o(hdr_naddr),
        .hdr_seq_o  (hdr_seq),
        .hdr_qos_o  (hdr_qos),
        .hdr_err_o  (hdr_err),
        .frame_cnt_o(frame_cnt),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_ready = bp_en ? ~m_ready : 1'b1;
    end

    // Monitor samples on the falling edge, between input updates and the next active edge.
    always @(negedge clk) begin
        if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
        if (hdr_valid) begin
            hv_pulses <= hv_pulses + 1;
            hv_cyc_q.push_back(cyc);
        end
        if (hdr_err) err_pulses <= err_pulses + 1;
    end

    function automatic bytes_t mk_hdr(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [15:0] dur, input logic [47:0] a1,
                                      input logic [47:0] a2, input logic [47:0] a3,
                                      input logic [15:0] seq, input logic [47:0] a4,
                                      input logic [15:0] qos, input bit with_a4,
                                      input bit with_qos, input int len);
        bytes_t f;
        f = {};
        f.push_back(b0);
        f.push_back(b1);
        for (int i = 0; i < 2; i++) f.push_back(dur[8*i +: 8]);
        for (int i = 0; i < 6; i++) f.push_back(a1[8*i +: 8]);
        for (int i = 0; i < 6; i++) f.push_back(a2[8*i +: 8]);
        for (int i = 0; i < 6; i++) f.push_back(a3[8*i +: 8]);
        for (int i = 0; i < 2; i++) f.push_back(seq[8*i +: 8]);
        if (with_a4) for (int i = 0; i < 6; i++) f.push_back(a4[8*i +: 8]);
        if (with_qos) for (int i = 0; i < 2; i++) f.push_back(qos[8*i +: 8]);
        while (f.size() > len) void'(f.pop_back());
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l, input bit trk,
                             output int unsigned acc);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        forever begin
            @(negedge clk);
            if (trk) begin
                checks++;
                if (s_ready !== m_ready) begin
                    errors++;
                    $display("FAIL s_ready_track: s_ready=%b m_ready=%b", s_ready, m_ready);
                end
            end
            if (s_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout: byte %h not accepted, want accepted", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic send_bytes(input bytes_t f, input int mark_idx, input int trk_from,
                              output int unsigned mark_cyc);
        int unsigned acc;
        mark_cyc = 0;
        foreach (f[i]) begin
            send_byte(f[i], (i == f.size() - 1), (i >= trk_from), acc);
            if (i == mark_idx) mark_cyc = acc;
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_payload(inout bytes_t f, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            f.push_back(base + 8'(i));
            exp_q.push_back({(i == n - 1), base + 8'(i)});
        end
    endtask

    task automatic test_reset();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL rst_hdr_valid: got %b want 0", hdr_valid); end
        checks++; if (hdr_err !== 1'b0) begin errors++; $display("FAIL rst_hdr_err: got %b want 0", hdr_err); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (hdr_addr1 !== 48'h0) begin errors++; $display("FAIL rst_addr1: got %h want 0", hdr_addr1); end
        checks++; if (hdr_naddr !== 3'd0) begin errors++; $display("FAIL rst_naddr: got %0d want 0", hdr_naddr); end
    endtask

    task automatic check_payload(input string name);
        logic [8:0] e, o;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_beats: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s_beat: got %h want %h", name, o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_data_basic();
        bytes_t f;
        int unsigned mc;
        int hv0 = hv_pulses;
        hv_cyc_q.delete();
        f = mk_hdr(8'h08, 8'h01, 16'h002c, 48'h112233445566, 48'h778899aabbcc,
                   48'hddeeff001122, 16'h3450, 48'h0, 16'h0, 1'b0, 1'b0, 24);
        add_payload(f, 8'hAA, 4);
        send_bytes(f, 23, 1000, mc);
        idle(3);
        checks++; if (hv_pulses - hv0 != 1) begin errors++; $display("FAIL basic_hv_count: got %0d want 1", hv_pulses - hv0); end
        checks++; if (hv_cyc_q.size() == 0 || hv_cyc_q[0] != mc) begin errors++; $display("FAIL basic_hv_timing: got %0d want %0d", (hv_cyc_q.size() > 0) ? hv_cyc_q[0] : 0, mc); end
        checks++; if (hdr_naddr !== 3'd3) begin errors++; $display("FAIL basic_naddr: got %0d want 3", hdr_naddr); end
        checks++; if (hdr_fc !== fc_t'(16'h0108)) begin errors++; $display("FAIL basic_fc: got %h want 0108", hdr_fc); end
        checks++; if (hdr_dur !== 16'h002c) begin errors++; $display("FAIL basic_dur: got %h want 002c", hdr_dur); end
        checks++; if (hdr_addr1 !== 48'h112233445566) begin errors++; $display("FAIL basic_a1: got %h want 112233445566", hdr_addr1); end
        checks++; if (hdr_addr2 !== 48'h778899aabbcc) begin errors++; $display("FAIL basic_a2: got %h want 778899aabbcc", hdr_addr2); end
        checks++; if (hdr_addr3 !== 48'hddeeff001122) begin errors++; $display("FAIL basic_a3: got %h want ddeeff001122", hdr_addr3); end
        checks++; if (hdr_seq !== 16'h3450) begin errors++; $display("FAIL basic_seq: got %h want 3450", hdr_seq); end
        checks++; if (hdr_addr4 !== 48'h0 || hdr_qos !== 16'h0) begin errors++; $display("FAIL basic_a4_qos: got %h/%h want 0/0", hdr_addr4, hdr_qos); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
        check_payload("basic");
    endtask

    task automatic test_qos_addr4();
        bytes_t f;
        int unsigned mc;
        hv_cyc_q.delete();
        f = mk_hdr(8'h88, 8'h03, 16'h0100, 48'h020000000001, 48'h020000000002,
                   48'h020000000003, 16'h0010, 48'h020000000004, 16'h0007, 1'b1, 1'b1, 32);
        add_payload(f, 8'h50, 3);
        send_bytes(f, 31, 1000, mc);
        idle(3);
        checks++; if (hv_cyc_q.size() == 0 || hv_cyc_q[0] != mc) begin errors++; $display("FAIL qos_hv_timing: got %0d want %0d", (hv_cyc_q.size() > 0) ? hv_cyc_q[0] : 0, mc); end
        checks++; if (hdr_naddr !== 3'd4) begin errors++; $display("FAIL qos_naddr: got %0d want 4", hdr_naddr); end
        checks++; if (hdr_addr4 !== 48'h020000000004) begin errors++; $display("FAIL qos_a4: got %h want 020000000004", hdr_addr4); end
        checks++; if (hdr_qos !== 16'h0007) begin errors++; $display("FAIL qos_qos: got %h want 0007", hdr_qos); end
        checks++; if (hdr_seq !== 16'h0010) begin errors++; $display("FAIL qos_seq: got %h want 0010", hdr_seq); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL qos_frame_cnt: got %0d want 2", frame_cnt); end
        check_payload("qos");
    endtask

    task automatic test_ctrl();
        bytes_t f;
        int unsigned mc;
        int hv0 = hv_pulses;
        hv_cyc_q.delete();
        f = mk_hdr(8'hD4, 8'h00, 16'h0000, 48'hcafe00000001, 48'h0, 48'h0, 16'h0, 48'h0,
                   16'h0, 1'b0, 1'b0, 10);
        send_bytes(f, 9, 1000, mc);
        idle(3);
        checks++; if (hv_pulses - hv0 != 1) begin errors++; $display("FAIL ack_hv_count: got %0d want 1", hv_pulses - hv0); end
        checks++; if (hv_cyc_q.size() == 0 || hv_cyc_q[0] != mc) begin errors++; $display("FAIL ack_hv_timing: got %0d want %0d", (hv_cyc_q.size() > 0) ? hv_cyc_q[0] : 0, mc); end
        checks++; if (hdr_naddr !== 3'd1) begin errors++; $display("FAIL ack_naddr: got %0d want 1", hdr_naddr); end
        checks++; if (hdr_addr1 !== 48'hcafe00000001) begin errors++; $display("FAIL ack_a1: got %h want cafe00000001", hdr_addr1); end
        checks++; if (hdr_addr2 !== 48'h0 || hdr_seq !== 16'h0) begin errors++; $display("FAIL ack_unused: got %h/%h want 0/0", hdr_addr2, hdr_seq); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL ack_frame_cnt: got %0d want 3", frame_cnt); end
        check_payload("ack");

        f = mk_hdr(8'hB4, 8'h00, 16'h0200, 48'hcafe00000002, 48'hcafe00000003, 48'h0, 16'h0,
                   48'h0, 16'h0, 1'b0, 1'b0, 16);
        add_payload(f, 8'h60, 2);
        send_bytes(f, 15, 1000, mc);
        idle(3);
        checks++; if (hdr_naddr !== 3'd2) begin errors++; $display("FAIL rts_naddr: got %0d want 2", hdr_naddr); end
        checks++; if (hdr_addr2 !== 48'hcafe00000003) begin errors++; $display("FAIL rts_a2: got %h want cafe00000003", hdr_addr2); end
        checks++; if (hdr_dur !== 16'h0200) begin errors++; $display("FAIL rts_dur: got %h want 0200", hdr_dur); end
        checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL rts_frame_cnt: got %0d want 4", frame_cnt); end
        check_payload("rts");
    endtask

    task automatic test_bad_version();
        bytes_t f;
        int unsigned mc;
        int hv0 = hv_pulses;
        int er0 = err_pulses;
        f = {};
        f.push_back(8'h09);
        for (int i = 0; i < 20; i++) f.push_back(8'(i + 1));
        send_bytes(f, 0, 1000, mc);
        idle(3);
        checks++; if (err_pulses - er0 != 1) begin errors++; $display("FAIL ver_err_pulse: got %0d want 1", err_pulses - er0); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL ver_err_cnt: got %0d want 1", err_cnt); end
        checks++; if (hv_pulses != hv0) begin errors++; $display("FAIL ver_no_hdr: got %0d want %0d", hv_pulses, hv0); end
        checks++; if (hdr_addr1 !== 48'hcafe00000002 || hdr_naddr !== 3'd2) begin errors++; $display("FAIL ver_fields_held: got %h/%0d want cafe00000002/2", hdr_addr1, hdr_naddr); end
        check_payload("ver");
    endtask

    task automatic test_back_to_back();
        bytes_t f;
        int unsigned mc;
        int hv0 = hv_pulses;
        int er0 = err_pulses;
        f = mk_hdr(8'h08, 8'h02, 16'h0033, 48'h0a0a0a0a0a0a, 48'h0b0b0b0b0b0b, 48'h0c0c0c0c0c0c,
                   16'h1110, 48'h0, 16'h0, 1'b0, 1'b0, 16);
        send_bytes(f, 0, 1000, mc);
        f = mk_hdr(8'h80, 8'h00, 16'h0044, 48'hffffffffffff, 48'h00000000beef,
                   48'h00000000beef, 16'h2220, 48'h0, 16'h0, 1'b0, 1'b0, 24);
        add_payload(f, 8'h70, 2);
        send_bytes(f, 23, 1000, mc);
        idle(3);
        checks++; if (err_pulses - er0 != 1) begin errors++; $display("FAIL runt_err_pulse: got %0d want 1", err_pulses - er0); end
        checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL runt_err_cnt: got %0d want 2", err_cnt); end
        checks++; if (hv_pulses - hv0 != 1) begin errors++; $display("FAIL b2b_hv_count: got %0d want 1", hv_pulses - hv0); end
        checks++; if (hdr_addr2 !== 48'h00000000beef) begin errors++; $display("FAIL b2b_a2: got %h want 00000000beef", hdr_addr2); end
        checks++; if (hdr_seq !== 16'h2220) begin errors++; $display("FAIL b2b_seq: got %h want 2220", hdr_seq); end
        checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want 5", frame_cnt); end
        check_payload("b2b");
    endtask

    task automatic test_backpressure_reset();
        bytes_t f;
        int unsigned mc;
        bp_en = 1'b1;
        f = mk_hdr(8'h08, 8'h00, 16'h0055, 48'h1, 48'h2, 48'h3, 16'h0, 48'h0, 16'h0,
                   1'b0, 1'b0, 24);
        add_payload(f, 8'h80, 6);
        send_bytes(f, 23, 24, mc);
        idle(1);
        bp_en = 1'b0;
        idle(3);
        checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL bp_frame_cnt: got %0d want 6", frame_cnt); end
        check_payload("bp");

        // Header plus two payload beats, then reset while still inside the payload.
        f = mk_hdr(8'h08, 8'h00, 16'h0066, 48'h4, 48'h5, 48'h6, 16'h0, 48'h0, 16'h0,
                   1'b0, 1'b0, 24);
        f.push_back(8'h90);
        f.push_back(8'h91);
        exp_q.push_back({1'b0, 8'h90});
        exp_q.push_back({1'b0, 8'h91});
        foreach (f[i]) send_byte(f[i], 1'b0, 1'b0, mc);
        #1 rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL mid_rst_m: got %b/%h want 0/00", m_valid, m_data); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_s_ready: got %b want 1", s_ready); end
        checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", frame_cnt, err_cnt); end
        checks++; if (hdr_addr1 !== 48'h0 || hdr_naddr !== 3'd0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_fields: got %h/%0d/%b want 0/0/0", hdr_addr1, hdr_naddr, hdr_valid); end
        idle(2);
        rst = 1'b0;
        idle(1);
        check_payload("pre_rst");

        f = mk_hdr(8'h08, 8'h01, 16'h0077, 48'h0000000000a1, 48'h0000000000a2,
                   48'h0000000000a3, 16'h0020, 48'h0, 16'h0, 1'b0, 1'b0, 24);
        add_payload(f, 8'hC0, 1);
        send_bytes(f, 23, 1000, mc);
        idle(3);
        checks++; if (hdr_addr1 !== 48'h0000000000a1 || hdr_naddr !== 3'd3) begin errors++; $display("FAIL post_rst_fields: got %h/%0d want 0000000000a1/3", hdr_addr1, hdr_naddr); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL post_rst_frame_cnt: got %0d want 1", frame_cnt); end
        check_payload("post_rst");
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        test_reset();
        test_data_basic();
        test_qos_addr4();
        test_ctrl();
        test_bad_version();
        test_back_to_back();
        test_backpressure_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
